// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-boundary double buffering.
// Optional macro SEVEN_SEG_HEX_EN: decode codes 10-15 as A,b,C,d,E,F instead of blank.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [DW-1:0]         DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]              state;
  logic [DW-1:0]           div;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    boundary_q;
  logic                    at_boundary;
  logic [3:0]              cur_code;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    // NOTE: every path assigns seg (default arm included), so no latch can be inferred.
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
      4'd10:   seg = 7'b1110111;
      4'd11:   seg = 7'b0011111;
      4'd12:   seg = 7'b1001110;
      4'd13:   seg = 7'b0111101;
      4'd14:   seg = 7'b1001111;
      4'd15:   seg = 7'b1000111;
`endif
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  assign cur_code    = active[4*idx +: 4];
  // The frame ends when the last slot of the last digit expires while still scanning.
  assign at_boundary = (state == SCAN) && enable && (div == DIV_LAST) && (idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      // NOTE: the digit buffers are reset too; a display must never show power-up garbage.
      state      <= IDLE;
      div        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      boundary_q <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= '0;
      dig_sel    <= '0;
    end else begin
      // frame_done lines up with dig_sel returning to digit 0, one edge after the wrap.
      boundary_q <= at_boundary;
      frame_done <= boundary_q;

      case (state)
        IDLE: begin
          seg_out <= '0;
          dig_sel <= '0;
          div     <= '0;
          idx     <= '0;
          if (load) active <= data_in;
          if (enable) state <= SCAN;
        end

        SCAN: begin
          if (!enable) begin
            state   <= IDLE;
            div     <= '0;
            idx     <= '0;
            seg_out <= '0;
            dig_sel <= '0;
          end else begin
            dig_sel <= ONE_HOT0 << idx;
            seg_out <= blank_mask[idx] ? 7'b0000000 : decode(cur_code);
            if (div == DIV_LAST) begin
              div <= '0;
              idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              div <= div + 1'b1;
            end
          end

          // A load on the boundary itself bypasses the shadow and drops any older pending data.
          if (at_boundary) begin
            if (load)         active <= data_in;
            else if (pending) active <= shadow;
            pending <= 1'b0;
          end else if (load) begin
            shadow  <= data_in;
            pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
